mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter OT_DEPTH, default 2, max outstanding accepted-but-unanswered requests (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_req  input  1  instruction-side request valid.
REQ-005 inst_req_bus  input  69  {wr[68], wstrb[67:64], addr[63:32], wdata[31:0]}.
REQ-006 inst_addr_ok  output  1  instruction request accepted this cycle.
REQ-007 inst_data_ok  output  1  instruction response valid this cycle.
REQ-008 inst_rdata  output  32  instruction read data, qualified by inst_data_ok.
REQ-009 data_req  input  1  data-side request valid.
REQ-010 data_req_bus  input  69  same layout as inst_req_bus.
REQ-011 data_addr_ok  output  1  data request accepted this cycle.
REQ-012 data_data_ok  output  1  data response valid this cycle.
REQ-013 data_rdata  output  32  data read data, qualified by data_data_ok.
REQ-014 bus_req  output  1  request to the shared memory port.
REQ-015 bus_req_bus  output  69  forwarded payload of the granted master.
REQ-016 bus_addr_ok  input  1  memory port accepted the request.
REQ-017 bus_data_ok  input  1  memory port returns one response, in order.
REQ-018 bus_rdata  input  32  memory port read data.

Function
REQ-019 Handshake: a request completes in a cycle where req && addr_ok; a master holds req and payload stable until then.
REQ-020 FSM states ARB_IDLE and ARB_HOLD.
REQ-021 In ARB_IDLE, grant is round-robin: if both masters request, grant the one not granted last; if one requests, grant it.
REQ-022 bus_req = (any candidate request) && !fifo_full; bus_req_bus = payload of the granted master. Both are combinational, so request latency is zero cycles.
REQ-023 In ARB_IDLE, if bus_req && !bus_addr_ok, latch the grant and go to ARB_HOLD.
REQ-024 In ARB_IDLE, if bus_req && bus_addr_ok, the request completes and the FSM stays in ARB_IDLE.
REQ-025 In ARB_HOLD, present only the latched master; no re-arbitration. On bus_addr_ok, go to ARB_IDLE.
REQ-026 <master>_addr_ok = bus_addr_ok && bus_req && (grant == master); never asserted to both masters.
REQ-027 On each completed request, push the master ID (0=inst, 1=data) into an in-order ID FIFO and update the last-grant pointer.
REQ-028 On bus_data_ok with FIFO non-empty, pop the head and assert data_ok to the head master only, in the same cycle (zero-cycle response latency).
REQ-029 bus_rdata drives both inst_rdata and data_rdata unchanged.
REQ-030 Full: bus_req is held 0 while the FIFO holds OT_DEPTH entries, even if a pop occurs in the same cycle. A pop frees space for the next cycle.
REQ-031 Simultaneous push and pop when not full: both happen; the count is unchanged.
REQ-032 bus_data_ok while the FIFO is empty: ignored; no data_ok to either master; state unchanged.
REQ-033 FIFO pointers wrap modulo OT_DEPTH; the count ranges 0..OT_DEPTH.

Reset
REQ-034 Reset sets FSM=ARB_IDLE, FIFO empty, and last-grant=inst, so data wins the first tie.
REQ-035 During reset and the cycle it is sampled, bus_req, inst/data_addr_ok and inst/data_data_ok SHALL be 0.
REQ-036 Reset mid-transaction discards outstanding IDs; late bus_data_ok after reset is handled per REQ-032.

Structure
REQ-037 The shared header holds MEM_REQ_BUS_WD=69, the field bit positions, and ID encodings ARB_ID_INST=0 and ARB_ID_DATA=1.
REQ-038 The ID FIFO is one sub-module, arb_id_fifo (width 1, depth OT_DEPTH, push/pop/full/empty/head).

Verification
REQ-039 Both req=1 from reset, bus_addr_ok=1 each cycle -> grants alternate data,inst,data; FIFO IDs 1,0,1.
REQ-040 data_req=1, bus_addr_ok=0 for 3 cycles, then inst_req=1 while held -> bus_req_bus stays the data payload until addr_ok; inst is granted next.
REQ-041 Accept inst read then data read; bus_data_ok twice with rdata 0x11111111 then 0x22222222 -> inst_data_ok with 0x11111111, then data_data_ok with 0x22222222.
REQ-042 OT_DEPTH=2, two accepted and no responses -> bus_req=0 with a pending req; a bus_data_ok cycle keeps bus_req=0; bus_req=1 the next cycle.
REQ-043 bus_data_ok=1 with the FIFO empty -> no data_ok pulse; a subsequent normal transaction is correct.
REQ-044 Assert reset while in ARB_HOLD with 1 outstanding -> outputs 0, FSM ARB_IDLE, FIFO empty the next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Request bus layout, master IDs and FSM encoding.
package mem_arbiter_pkg;

  localparam int MEM_REQ_BUS_WD = 69;

  localparam int MRB_WR_BIT   = 68;
  localparam int MRB_WSTRB_HI = 67;
  localparam int MRB_WSTRB_LO = 64;
  localparam int MRB_ADDR_HI  = 63;
  localparam int MRB_ADDR_LO  = 32;
  localparam int MRB_WDATA_HI = 31;
  localparam int MRB_WDATA_LO = 0;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  typedef logic [MEM_REQ_BUS_WD-1:0] mem_req_bus_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

  // On a tie the master that did not win last time gets the port.
  function automatic logic rr_pick(
    input logic last,
    input logic ireq,
    input logic dreq
  );
    logic g;
    unique case ({ireq, dreq})
      2'b11:   g = ~last;
      2'b01:   g = ARB_ID_DATA;
      default: g = ARB_ID_INST;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_id_fifo.sv
// In-order FIFO of master IDs for accepted-but-unanswered requests.
// Pointers wrap naturally; depth must be a power of two.
module arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one split-transaction memory port
// between an instruction and a data master; responses return in order.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OT_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inst_req,
  input  logic [MEM_REQ_BUS_WD-1:0] inst_req_bus,
  output logic                      inst_addr_ok,
  output logic                      inst_data_ok,
  output logic [31:0]               inst_rdata,
  input  logic                      data_req,
  input  logic [MEM_REQ_BUS_WD-1:0] data_req_bus,
  output logic                      data_addr_ok,
  output logic                      data_data_ok,
  output logic [31:0]               data_rdata,
  output logic                      bus_req,
  output logic [MEM_REQ_BUS_WD-1:0] bus_req_bus,
  input  logic                      bus_addr_ok,
  input  logic                      bus_data_ok,
  input  logic [31:0]               bus_rdata
);

  arb_state_e state_q;
  logic       hold_id_q;
  logic       last_q;

  logic grant;
  logic cand;
  logic full;
  logic empty;
  logic head;
  logic push;
  logic pop;

  // A held request keeps its grant until accepted.
  always_comb begin
    grant = rr_pick(last_q, inst_req, data_req);
    cand  = inst_req | data_req;
    if (state_q == ARB_HOLD) begin
      grant = hold_id_q;
      cand  = hold_id_q ? data_req : inst_req;
    end
  end

  assign bus_req     = cand && !full && !reset;
  assign bus_req_bus = (grant == ARB_ID_DATA) ? data_req_bus : inst_req_bus;

  assign push = bus_req && bus_addr_ok;
  assign pop  = bus_data_ok && !empty && !reset;

  assign inst_addr_ok = push && (grant == ARB_ID_INST);
  assign data_addr_ok = push && (grant == ARB_ID_DATA);

  assign inst_data_ok = pop && (head == ARB_ID_INST);
  assign data_data_ok = pop && (head == ARB_ID_DATA);

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  arb_id_fifo #(
    .DEPTH (OT_DEPTH),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .din_i   (grant),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      hold_id_q <= ARB_ID_INST;
      last_q    <= ARB_ID_INST;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (bus_req && !bus_addr_ok) begin
            state_q   <= ARB_HOLD;
            hold_id_q <= grant;
          end
        end
        ARB_HOLD: begin
          if (push) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
      if (push) last_q <= grant;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed steps queue expected
// grants/responses, a negedge monitor pops and compares them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req;
  logic [68:0] inst_req_bus, data_req_bus;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req;
  logic [68:0] bus_req_bus;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  logic [69:0] gq[$];
  logic [32:0] rq[$];

  localparam logic [68:0] IPAY0 = {1'b0, 4'h0, 32'h0000_1000, 32'h0};
  localparam logic [68:0] IPAY1 = {1'b0, 4'h0, 32'h0000_1004, 32'h0};
  localparam logic [68:0] DPAY0 = {1'b1, 4'hF, 32'h8000_0000, 32'hDEAD_BEEF};
  localparam logic [68:0] DPAY1 = {1'b0, 4'h0, 32'h8000_0010, 32'h0};
  localparam logic [68:0] DPAY2 = {1'b1, 4'h3, 32'h8000_0020, 32'hCAFE_0001};
  localparam logic [68:0] NOPAY = '0;

  mem_arbiter #(.OT_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_req_bus (inst_req_bus),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_req_bus (data_req_bus),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_req_bus  (bus_req_bus),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [69:0] ge;
    logic [32:0] re;
    logic        gid;
    logic [31:0] rd;
    if (inst_addr_ok && data_addr_ok) begin
      checks++; errors++;
      $display("FAIL grant_both inst=1 data=1 required one-hot");
    end else if (inst_addr_ok || data_addr_ok) begin
      gid = data_addr_ok;
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_unexp id=%0b required none", gid);
      end else begin
        ge = gq.pop_front();
        if (gid !== ge[69] || bus_req_bus !== ge[68:0]) begin
          errors++;
          $display("FAIL grant id=%0b bus=%h required id=%0b bus=%h",
                   gid, bus_req_bus, ge[69], ge[68:0]);
        end
      end
    end
    if (inst_data_ok && data_data_ok) begin
      checks++; errors++;
      $display("FAIL resp_both inst=1 data=1 required one-hot");
    end else if (inst_data_ok || data_data_ok) begin
      gid = data_data_ok;
      rd  = gid ? data_rdata : inst_rdata;
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL resp_unexp id=%0b required none", gid);
      end else begin
        re = rq.pop_front();
        if (gid !== re[32] || rd !== re[31:0]) begin
          errors++;
          $display("FAIL resp id=%0b rdata=%h required id=%0b rdata=%h",
                   gid, rd, re[32], re[31:0]);
        end
      end
    end
  end

  task automatic expg(input logic id, input logic [68:0] pay);
    gq.push_back({id, pay});
  endtask

  task automatic expr(input logic id, input logic [31:0] rd);
    rq.push_back({id, rd});
  endtask

  task automatic step(
    input logic        ir,
    input logic [68:0] ib,
    input logic        dr,
    input logic [68:0] db,
    input logic        aok,
    input logic        dok,
    input logic [31:0] rd,
    input int          exp_breq,
    input logic        chk_bus,
    input logic [68:0] exp_bus
  );
    inst_req     = ir;
    inst_req_bus = ib;
    data_req     = dr;
    data_req_bus = db;
    bus_addr_ok  = aok;
    bus_data_ok  = dok;
    bus_rdata    = rd;
    @(negedge clk);
    if (exp_breq >= 0) begin
      checks++;
      if (bus_req !== exp_breq[0]) begin
        errors++;
        $display("FAIL bus_req got %0b required %0d", bus_req, exp_breq);
      end
    end
    if (chk_bus) begin
      checks++;
      if (bus_req_bus !== exp_bus) begin
        errors++;
        $display("FAIL bus_req_bus got %h required %h", bus_req_bus, exp_bus);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    inst_req = 0; data_req = 0;
    inst_req_bus = '0; data_req_bus = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    @(posedge clk); #1;
    // reset gates everything even with live inputs
    step(1, IPAY0, 1, DPAY0, 1, 1, 32'hAAAA_AAAA, 0, 0, NOPAY);
    step(1, IPAY0, 1, DPAY0, 1, 1, 32'hAAAA_AAAA, 0, 0, NOPAY);
    reset = 1'b0;

    expg(1, DPAY0);
    step(1, IPAY0, 1, DPAY0, 1, 0, 32'h0, 1, 0, NOPAY);
    expg(0, IPAY0); expr(1, 32'h0000_0001);
    step(1, IPAY0, 1, DPAY1, 1, 1, 32'h0000_0001, 1, 0, NOPAY);
    expg(1, DPAY1); expr(0, 32'h0000_0002);
    step(1, IPAY1, 1, DPAY1, 1, 1, 32'h0000_0002, 1, 0, NOPAY);
    expr(1, 32'h0000_0003);
    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h0000_0003, 0, 0, NOPAY);

    step(0, NOPAY, 1, DPAY2, 0, 0, 32'h0, 1, 1, DPAY2);
    step(0, NOPAY, 1, DPAY2, 0, 0, 32'h0, 1, 1, DPAY2);
    step(0, NOPAY, 1, DPAY2, 0, 0, 32'h0, 1, 1, DPAY2);
    step(1, IPAY1, 1, DPAY2, 0, 0, 32'h0, 1, 1, DPAY2);
    expg(1, DPAY2);
    step(1, IPAY1, 1, DPAY2, 1, 0, 32'h0, 1, 1, DPAY2);
    expg(0, IPAY1); expr(1, 32'h0000_0004);
    step(1, IPAY1, 0, NOPAY, 1, 1, 32'h0000_0004, 1, 1, IPAY1);
    expr(0, 32'h0000_0005);
    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h0000_0005, 0, 0, NOPAY);

    expg(0, IPAY0);
    step(1, IPAY0, 0, NOPAY, 1, 0, 32'h0, 1, 0, NOPAY);
    expg(1, DPAY0);
    step(0, NOPAY, 1, DPAY0, 1, 0, 32'h0, 1, 0, NOPAY);
    expr(0, 32'h1111_1111);
    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h1111_1111, 0, 0, NOPAY);
    expr(1, 32'h2222_2222);
    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h2222_2222, 0, 0, NOPAY);

    // full FIFO blocks even in the pop cycle
    expg(0, IPAY0);
    step(1, IPAY0, 0, NOPAY, 1, 0, 32'h0, 1, 0, NOPAY);
    expg(1, DPAY1);
    step(0, NOPAY, 1, DPAY1, 1, 0, 32'h0, 1, 0, NOPAY);
    step(1, IPAY1, 0, NOPAY, 1, 0, 32'h0, 0, 0, NOPAY);
    expr(0, 32'h0000_0006);
    step(1, IPAY1, 0, NOPAY, 1, 1, 32'h0000_0006, 0, 0, NOPAY);
    expg(0, IPAY1);
    step(1, IPAY1, 0, NOPAY, 1, 0, 32'h0, 1, 0, NOPAY);
    expr(1, 32'h0000_0007);
    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h0000_0007, 0, 0, NOPAY);
    expr(0, 32'h0000_0008);
    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h0000_0008, 0, 0, NOPAY);

    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h0000_0009, 0, 0, NOPAY);
    expg(1, DPAY0);
    step(0, NOPAY, 1, DPAY0, 1, 0, 32'h0, 1, 0, NOPAY);
    expr(1, 32'h0000_000A);
    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h0000_000A, 0, 0, NOPAY);

    // reset while holding data with one inst outstanding
    expg(0, IPAY0);
    step(1, IPAY0, 0, NOPAY, 1, 0, 32'h0, 1, 0, NOPAY);
    step(0, NOPAY, 1, DPAY2, 0, 0, 32'h0, 1, 1, DPAY2);
    reset = 1'b1;
    step(0, NOPAY, 1, DPAY2, 1, 1, 32'h0000_000B, 0, 0, NOPAY);
    reset = 1'b0;
    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h0000_000C, 0, 0, NOPAY);
    expg(0, IPAY0);
    step(1, IPAY0, 0, NOPAY, 1, 0, 32'h0, 1, 0, NOPAY);
    expg(1, DPAY0);
    step(1, IPAY1, 1, DPAY0, 1, 0, 32'h0, 1, 0, NOPAY);
    expr(0, 32'h0000_000D);
    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h0000_000D, 0, 0, NOPAY);
    expr(1, 32'h0000_000E);
    step(0, NOPAY, 0, NOPAY, 0, 1, 32'h0000_000E, 0, 0, NOPAY);

    step(0, NOPAY, 0, NOPAY, 0, 0, 32'h0, 0, 0, NOPAY);
    checks++;
    if (gq.size() != 0) begin
      errors++;
      $display("FAIL grants_left got %0d required 0", gq.size());
    end
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL resps_left got %0d required 0", rq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
